pwm_channel_bank: RTL and testbench

//  N-channel, W-bit PWM engine driving the lamp LED stages (R,G,B,W by default), successor to the fixed 4x8-bit PWM.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_channel_bank_if.sv | 17 +
 rtl/pwm_channel.sv | 67 ++++++
 rtl/pwm_channel_bank.sv | 86 ++++++++
 tb/tb_pwm_channel_bank.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM channel bank.
//   - Default geometry (channel count, duty width, terminal count, phase stagger).
//   - Channel index constants for the lamp LED stages.
//   - phase_offset(): constant per-channel phase offset, reduced into one period.
// Optional feature macro: PWM_PHASE_STAGGER_EN (consumed by pwm_channel_bank.sv).
package pwm_pkg;

  localparam int N_CH_DEF    = 4;
  localparam int DUTY_W_DEF  = 8;
  localparam int MAX_CNT_DEF = 254;
  localparam int STAGGER_DEF = 64;

  localparam int CH_RED   = 0;
  localparam int CH_GREEN = 1;
  localparam int CH_BLUE  = 2;
  localparam int CH_WHITE = 3;

  // Offset of channel ch relative to the shared counter, already reduced modulo
  // the period so the channel only needs a single conditional subtract.
  function automatic int phase_offset(int ch, int stagger, int max_cnt, bit stagger_on);
    return stagger_on ? (ch * stagger) % (max_cnt + 1) : 0;
  endfunction

endpackage

// File: rtl/pwm_channel_bank_if.sv
// Duty-load bus between the colour path (master) and the PWM bank (slave).
//   duty_in      packed duties, channel i = duty_in[i*DUTY_W +: DUTY_W]
//   duty_load    one-clk strobe: capture duty_in into the shadow registers
//   load_pending shadow holds a value that has not been applied yet
interface pwm_channel_bank_if #(
  parameter int N_CH   = 4,
  parameter int DUTY_W = 8
) ();

  logic [N_CH*DUTY_W-1:0] duty_in;
  logic                   duty_load;
  logic                   load_pending;

  modport master (output duty_in, output duty_load, input  load_pending);
  modport slave  (input  duty_in, input  duty_load, output load_pending);

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty, active duty, phase compare, registered output.
//   clk, rst_n   clock, asynchronous active-low reset
//   enable_i     0 = output low, active copies shadow every clock
//   wrap_i       counter wraps on this clock: active takes the (old) shadow
//   duty_load_i  capture duty_i into the shadow register
//   duty_i       new duty word
//   cnt_i        shared period counter
//   pwm_o        registered PWM output
module pwm_channel #(
  parameter int DUTY_W    = 8,
  parameter int MAX_CNT   = 254,
  parameter int PHASE_OFS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              wrap_i,
  input  logic              duty_load_i,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic [DUTY_W-1:0] cnt_i,
  output logic              pwm_o
);

  localparam logic [DUTY_W:0] PERIOD = (DUTY_W+1)'(MAX_CNT + 1);
  localparam logic [DUTY_W:0] OFS    = (DUTY_W+1)'(PHASE_OFS);

  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic              pwm_q,    pwm_d;
  logic [DUTY_W:0]   phase_sum;
  logic [DUTY_W:0]   phase;

  // Both cnt_i and OFS are below PERIOD, so one conditional subtract wraps the
  // sum back into [0, MAX_CNT]. With a zero offset the subtract never fires.
  assign phase_sum = {1'b0, cnt_i} + OFS;
  assign phase     = (phase_sum >= PERIOD) ? phase_sum - PERIOD : phase_sum;

  // NOTE: every variable driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (duty_load_i) shadow_d = duty_i;
    // Active samples the shadow as it stood before this clock's load, so a load
    // coincident with wrap lands one period later.
    if (!enable_i || wrap_i) active_d = shadow_q;
    // Duty 0 never beats phase (always low); duty > MAX_CNT always does.
    pwm_d = enable_i && (phase < {1'b0, active_q});
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_channel_bank.sv
// N-channel, W-bit PWM engine for the lamp LED stages.
//   clk, rst_n    clock, asynchronous active-low reset
//   tick_en       counter advance strobe (prescaled clock enable)
//   enable        1 = run, 0 = counter held at 0, outputs low
//   duty_if       slave side of the duty-load bus (duty_in, duty_load, load_pending)
//   period_start  one-clk pulse after the counter wraps to 0
//   pwm_out       registered PWM outputs
// Optional feature macro: PWM_PHASE_STAGGER_EN -- channel i compares against
// (cnt + i*STAGGER) mod (MAX_CNT+1) so rising edges are spread over the period.
// Without it every channel compares against cnt directly and STAGGER is ignored.
module pwm_channel_bank
  import pwm_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int MAX_CNT = MAX_CNT_DEF,
  parameter int STAGGER = STAGGER_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_en,
  input  logic                enable,
  pwm_channel_bank_if.slave   duty_if,
  output logic                period_start,
  output logic [N_CH-1:0]     pwm_out
);

`ifdef PWM_PHASE_STAGGER_EN
  localparam bit STAGGER_ON = 1'b1;
`else
  localparam bit STAGGER_ON = 1'b0;
`endif

  localparam logic [DUTY_W-1:0] MAX_V = DUTY_W'(MAX_CNT);

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              load_pending_q, load_pending_d;
  logic              period_start_q;
  logic              wrap;

  assign wrap = tick_en && enable && (cnt_q == MAX_V);

  always_comb begin
    cnt_d          = cnt_q;
    load_pending_d = load_pending_q;
    if (!enable)      cnt_d = '0;
    else if (tick_en) cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
    // A load always wins, including on the wrap clock and while disabled: the
    // value it writes into the shadow has not reached the active register yet.
    if (duty_if.duty_load)    load_pending_d = 1'b1;
    else if (!enable || wrap) load_pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      load_pending_q <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      load_pending_q <= load_pending_d;
      period_start_q <= wrap;
    end
  end

  assign period_start         = period_start_q;
  assign duty_if.load_pending = load_pending_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel #(
      .DUTY_W    (DUTY_W),
      .MAX_CNT   (MAX_CNT),
      .PHASE_OFS (phase_offset(i, STAGGER, MAX_CNT, STAGGER_ON))
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable_i    (enable),
      .wrap_i      (wrap),
      .duty_load_i (duty_if.duty_load),
      .duty_i      (duty_if.duty_in[i*DUTY_W +: DUTY_W]),
      .cnt_i       (cnt_q),
      .pwm_o       (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Self-checking bench for pwm_channel_bank: directed steps plus a randomized
// section, all compared against a period/phase reference model.
module tb_pwm_channel_bank;
  import pwm_pkg::*;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXC = 254;
  localparam int PER  = MAXC + 1;
  localparam int STG  = 64;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int STAGGER_ON = 1;
`else
  localparam int STAGGER_ON = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick_en;
  logic         enable;
  logic         period_start;
  logic [N-1:0] pwm_out;

  pwm_channel_bank_if #(.N_CH(N), .DUTY_W(W)) duty_if ();

  pwm_channel_bank #(
    .N_CH(N), .DUTY_W(W), .MAX_CNT(MAXC), .STAGGER(STG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_en      (tick_en),
    .enable       (enable),
    .duty_if      (duty_if),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: counter position within the period, shadow/active duties.
  int           m_cnt;
  int           m_shadow [N];
  int           m_active [N];
  logic [N-1:0] m_pwm;
  logic         m_pend;
  logic         m_ps;
  int           hi_cnt [N];
  int           clk_idx = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int phase(int c, int ch);
    return (c + ch * STG * STAGGER_ON) % PER;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pwm = '0; m_pend = 1'b0; m_ps = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = 0; m_active[i] = 0;
    end
  endtask

  task automatic clear_hi();
    for (int i = 0; i < N; i++) hi_cnt[i] = 0;
  endtask

  // One clock: advance the model from the current inputs, then compare outputs.
  task automatic step();
    bit wrap;
    wrap = tick_en && enable && (m_cnt == MAXC);
    for (int i = 0; i < N; i++) begin
      m_pwm[i] = enable && (phase(m_cnt, i) < m_active[i]);
      if (!enable || wrap) m_active[i] = m_shadow[i];
      if (duty_if.duty_load) m_shadow[i] = int'(duty_if.duty_in[i*W +: W]);
    end
    if (!enable)      m_cnt = 0;
    else if (tick_en) m_cnt = wrap ? 0 : m_cnt + 1;
    if (duty_if.duty_load)    m_pend = 1'b1;
    else if (!enable || wrap) m_pend = 1'b0;
    m_ps = wrap;
    @(posedge clk);
    #1;
    clk_idx++;
    for (int i = 0; i < N; i++) if (pwm_out[i] === 1'b1) hi_cnt[i]++;
    check("pwm_out", 32'(pwm_out), 32'(m_pwm));
    check("load_pending", 32'(duty_if.load_pending), 32'(m_pend));
    check("period_start", 32'(period_start), 32'(m_ps));
  endtask

  task automatic load(logic [N*W-1:0] d);
    duty_if.duty_in   = d;
    duty_if.duty_load = 1'b1;
    step();
    duty_if.duty_load = 1'b0;
  endtask

  // Load while disabled, let one more disabled clock copy shadow to active, then run.
  task automatic load_and_start(logic [N*W-1:0] d);
    enable = 1'b0;
    load(d);
    step();
    enable = 1'b1;
  endtask

  int expd [N];
  int t1, t2, r_hi;

  initial begin
    rst_n = 1'b0; tick_en = 1'b0; enable = 1'b0;
    duty_if.duty_in = '0; duty_if.duty_load = 1'b0;
    model_reset();
    clear_hi();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_pend", 32'(duty_if.load_pending), 32'd0);
    check("reset_ps", 32'(period_start), 32'd0);
    rst_n = 1'b1;
    step();

    // T1: {W,B,G,R} = {0,64,128,255}, tick every clock.
    tick_en = 1'b1;
    load_and_start({8'd0, 8'd64, 8'd128, 8'd255});
    repeat (20) step();
    clear_hi();
    repeat (PER) step();
    expd = '{255, 128, 64, 0};
    for (int i = 0; i < N; i++) check($sformatf("t1_hi_ch%0d", i), 32'(hi_cnt[i]), 32'(expd[i]));

    // T2: load R=10 at cnt=100; old duty holds until wrap.
    for (int k = 0; k < 2 * PER && m_cnt != 100; k++) step();
    check("t2_at_cnt100", 32'(m_cnt), 32'd100);
    load({8'd0, 8'd64, 8'd128, 8'd10});
    check("t2_pend_set", 32'(duty_if.load_pending), 32'd1);
    for (int k = 0; k < 2 * PER && !m_ps; k++) step();
    check("t2_wrap_seen", 32'(period_start), 32'd1);
    check("t2_pend_clear", 32'(duty_if.load_pending), 32'd0);
    clear_hi();
    repeat (PER) step();
    check("t2_r_hi", 32'(hi_cnt[CH_RED]), 32'd10);

    // T3: load R=200 on the exact wrap tick.
    for (int k = 0; k < 2 * PER && m_cnt != MAXC; k++) step();
    load({8'd0, 8'd64, 8'd128, 8'd200});
    check("t3_ps", 32'(period_start), 32'd1);
    check("t3_pend_kept", 32'(duty_if.load_pending), 32'd1);
    clear_hi();
    repeat (PER) step();
    check("t3_r_old", 32'(hi_cnt[CH_RED]), 32'd10);
    clear_hi();
    repeat (PER) step();
    check("t3_r_new", 32'(hi_cnt[CH_RED]), 32'd200);

    // Randomized traffic: sparse ticks, loads (including edge duties), enable toggles.
    for (int k = 0; k < 2500; k++) begin
      tick_en = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) begin
        duty_if.duty_in = $urandom;
        if ($urandom_range(0, 3) == 0) duty_if.duty_in[W-1:0] = (W)'($urandom_range(0, 2) == 0 ? 0 : MAXC - 1 + $urandom_range(0, 2));
        duty_if.duty_load = 1'b1;
      end
      step();
      duty_if.duty_load = 1'b0;
    end

    // T4: tick every 4th clock -> 1020-clock period, R=1 is a 4-clock pulse.
    tick_en = 1'b0;
    load_and_start({8'd0, 8'd0, 8'd0, 8'd1});
    t1 = -1; t2 = -1; r_hi = 0;
    for (int k = 0; k < 3000 && t2 < 0; k++) begin
      tick_en = (k % 4 == 0);
      step();
      if (t1 >= 0 && pwm_out[CH_RED] === 1'b1) r_hi++;
      if (period_start === 1'b1) begin
        if (t1 < 0) t1 = clk_idx; else t2 = clk_idx;
      end
    end
    check("t4_two_pulses", 32'(t2 >= 0), 32'd1);
    check("t4_spacing", 32'(t2 - t1), 32'd1020);
    check("t4_r_width", 32'(r_hi), 32'd4);

    // T5: async reset while all outputs are high.
    tick_en = 1'b1;
    load_and_start({N*W{1'b1}});
    repeat (3) step();
    check("t5_all_high", 32'(pwm_out), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_low", 32'(pwm_out), 32'd0);
    check("t5_async_pend", 32'(duty_if.load_pending), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("t5_held_low", 32'(pwm_out), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (PER + 5) step();
    check("t5_low_after", 32'(pwm_out), 32'd0);
    load_and_start({8'd32, 8'd32, 8'd32, 8'd32});
    clear_hi();
    repeat (PER) step();
    for (int i = 0; i < N; i++) check($sformatf("t5_hi_ch%0d", i), 32'(hi_cnt[i]), 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
